stim_trace_recorder: RTL

- Writer-side counterpart to the stimulus replay bench: samples the per-cycle DUT stimulus fields (`__obs`, `register`, `count`, `in`) and packs each sample into the 38-bit opcode word format that replay memory consumes.
- Buffers packed words in an internal RAM, then drains them over a valid/ready stream so the host can write `data.mem` for later concolic replay.
- Sits beside the DUT in capture runs.

---
 rtl/conc_trace_pkg.sv | 33 +++
 rtl/stim_trace_recorder_if.sv | 25 ++
 rtl/trace_ram.sv | 28 ++
 rtl/stim_trace_recorder.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/conc_trace_pkg.sv
// Shared types and opcode-word layout for the stimulus trace recorder.
// Optional stamp RAM is enabled with STIM_TRACE_STAMP_EN.
package conc_trace_pkg;

  localparam int OPW     = 38;
  localparam int OBS_BIT = 37;
  localparam int REG_BIT = 36;
  localparam int CNT_MSB = 35;
  localparam int CNT_LSB = 32;
  localparam int IN_MSB  = 31;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } trace_state_t;

  function automatic logic [OPW-1:0] pack_word(
    input logic        obs,
    input logic        regb,
    input logic [3:0]  cnt,
    input logic [31:0] din
  );
    logic [OPW-1:0] w;
    w                  = '0;
    w[OBS_BIT]         = obs;
    w[REG_BIT]         = regb;
    w[CNT_MSB:CNT_LSB] = cnt;
    w[IN_MSB:0]        = din;
    return w;
  endfunction

endpackage

// File: rtl/stim_trace_recorder_if.sv
// Drain stream of the trace recorder: valid/ready plus word, index,
// last marker and capture stamp.
interface stim_trace_recorder_if #(
  parameter int AW = 4
);
  import conc_trace_pkg::*;

  logic           valid;
  logic           ready;
  logic [OPW-1:0] data;
  logic [AW-1:0]  addr;
  logic           last;
  logic [31:0]    stamp;

  modport master (
    output valid, data, addr, last, stamp,
    input  ready
  );

  modport slave (
    input  valid, data, addr, last, stamp,
    output ready
  );

endinterface

// File: rtl/trace_ram.sv
// Simple dual-port RAM, one write and one registered read port.
// The read register clears on reset so outputs start at zero.
module trace_ram #(
  parameter int W     = 38,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/stim_trace_recorder.sv
// Captures packed DUT stimulus words, then drains them over a stream.
// Define STIM_TRACE_STAMP_EN to store and emit per-word capture stamps.
module stim_trace_recorder
  import conc_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        smp_obs,
  input  logic        smp_register,
  input  logic [3:0]  smp_count,
  input  logic [31:0] smp_in,
  stim_trace_recorder_if.master rd,
  output logic        busy,
  output logic        overflow
);

  trace_state_t   state, state_d;
  logic [AW-1:0]  wr_ptr, wr_ptr_d;
  logic [AW-1:0]  rd_ptr, rd_ptr_d;
  logic [AW-1:0]  last_idx;
  logic [31:0]    cyc, cyc_d;
  logic           ovf_d;
  logic           vld, vld_d;
  logic           we, hs, empty, last;
  logic [OPW-1:0] word, q;

  assign word = pack_word(smp_obs, smp_register,
                          smp_count, smp_in);

  // wr_ptr wraps to 0 after a full capture, so overflow disambiguates
  assign empty    = !overflow && (wr_ptr == '0);
  assign last_idx = overflow ? '1 : wr_ptr - AW'(1);
  assign hs       = vld && rd.ready;
  assign last     = vld && (rd_ptr == last_idx);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cyc      <= '0;
      overflow <= 1'b0;
      vld      <= 1'b0;
    end else begin
      state    <= state_d;
      wr_ptr   <= wr_ptr_d;
      rd_ptr   <= rd_ptr_d;
      cyc      <= cyc_d;
      overflow <= ovf_d;
      vld      <= vld_d;
    end
  end

  always_comb begin
    state_d  = state;
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    cyc_d    = cyc;
    ovf_d    = overflow;
    vld_d    = vld;
    we       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d  = CAPTURE;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          cyc_d    = '0;
          ovf_d    = 1'b0;
        end
      end
      CAPTURE: begin
        if (stop) begin
          state_d = DRAIN;
        end else begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr + AW'(1);
          cyc_d    = cyc + 32'd1;
          if (wr_ptr == AW'(DEPTH - 1)) begin
            ovf_d   = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (empty) begin
          state_d = IDLE;
        end else if (hs && last) begin
          state_d  = IDLE;
          vld_d    = 1'b0;
          rd_ptr_d = '0;
        end else begin
          vld_d = 1'b1;
          if (hs) rd_ptr_d = rd_ptr + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // read address looks one step ahead so a handshake streams back-to-back
  trace_ram #(.W(OPW), .DEPTH(DEPTH), .AW(AW)) u_word (
    .clk   (clk),
    .rst_n (reset),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (word),
    .raddr (rd_ptr_d),
    .rdata (q)
  );

`ifdef STIM_TRACE_STAMP_EN
  logic [31:0] stamp_q;

  trace_ram #(.W(32), .DEPTH(DEPTH), .AW(AW)) u_stamp (
    .clk   (clk),
    .rst_n (reset),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (cyc),
    .raddr (rd_ptr_d),
    .rdata (stamp_q)
  );

  assign rd.stamp = vld ? stamp_q : '0;
`else
  assign rd.stamp = '0;
`endif

  assign rd.valid = vld;
  assign rd.data  = vld ? q : '0;
  assign rd.addr  = rd_ptr;
  assign rd.last  = last;
  assign busy     = (state != IDLE);

endmodule
